// File: rtl/roi_shr_harness_pkg.sv
// Shared constants and elaboration-time helpers for the ROI shift-register harness.
package roi_shr_pkg;

    // Strobe-mode selectors for the harness AUTO_STB parameter.
    localparam bit STB_EXT  = 1'b0;
    localparam bit STB_AUTO = 1'b1;

    // Ceiling log2, valid for v >= 1; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Frame length: enough cycles to fill the longer of the two chains.
    function automatic int unsigned frame(input int unsigned din_n, input int unsigned dout_n);
        return max(din_n, dout_n);
    endfunction

endpackage

// File: rtl/roi_shr_harness_if.sv
// Pin-side and ROI-side signal bundle for roi_shr_harness.
//   i_stb        load strobe
//   i_di         serial data in
//   i_dout       parallel word from the ROI (DOUT_N bits)
//   o_do         serial data out
//   o_din        parallel word to the ROI (max(DIN_N,1) bits, 0 when DIN_N = 0)
//   o_ld         one-cycle pulse after each load
//   o_frame_full at least DIN_N bits shifted in since the last load
interface roi_shr_harness_if #(
    parameter int unsigned DIN_N  = 8,
    parameter int unsigned DOUT_N = 8
);
    localparam int unsigned DIN_W = roi_shr_pkg::max(DIN_N, 1);

    logic              i_stb;
    logic              i_di;
    logic [DOUT_N-1:0] i_dout;
    logic              o_do;
    logic [DIN_W-1:0]  o_din;
    logic              o_ld;
    logic              o_frame_full;

    modport master (
        output i_stb, i_di, i_dout,
        input  o_do, o_din, o_ld, o_frame_full
    );

    modport slave (
        input  i_stb, i_di, i_dout,
        output o_do, o_din, o_ld, o_frame_full
    );

endinterface

// File: rtl/roi_shr_harness_shr_chain.sv
// Shift register: serial in at bit 0, parallel load, MSB serial out.
//   clk, rst  clock and synchronous active-high reset
//   i_load    parallel load (overrides the shift)
//   i_ser     serial input
//   i_par     parallel load value
//   o_msb     serial output (MSB)
//   o_par     current register contents
module shr_chain #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_ser,
    input  logic [W-1:0] i_par,
    output logic         o_msb,
    output logic [W-1:0] o_par
);

    logic [W-1:0] r_shr;
    logic [W-1:0] w_shifted;

    // A one-bit chain has no upper bits to carry along.
    if (W == 1) begin : g_single
        assign w_shifted = i_ser;
    end else begin : g_multi
        assign w_shifted = {r_shr[W-2:0], i_ser};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shr <= '0;
        end else if (i_load) begin
            r_shr <= i_par;
        end else begin
            r_shr <= w_shifted;
        end
    end

    assign o_msb = r_shr[W-1];
    assign o_par = r_shr;

endmodule

// File: rtl/roi_shr_harness.sv
// Serial-in/serial-out harness around a timing ROI: an input chain feeds the
// ROI's parallel din, an output chain captures its dout and shifts it out.
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   roi_shr_harness_if.slave (stb, di, do, din, dout, ld, frame_full)
// Parameters: DIN_N (0 = no input chain), DOUT_N (>= 1), AUTO_STB (self-strobe
// every FRAME cycles when STB_AUTO).
module roi_shr_harness
    import roi_shr_pkg::*;
#(
    parameter int unsigned DIN_N    = 8,
    parameter int unsigned DOUT_N   = 8,
    parameter bit          AUTO_STB = STB_EXT
) (
    input  logic                clk,
    input  logic                rst,
    roi_shr_harness_if.slave    bus
);

    localparam int unsigned FRAME = frame(DIN_N, DOUT_N);
    localparam int unsigned CNT_W = clog2(FRAME + 1);

    logic [CNT_W-1:0]  r_bcnt;
    logic [CNT_W-1:0]  w_bcnt_nxt;
    logic              r_ld;
    logic              r_frame_full;
    logic              w_full_nxt;
    logic              w_auto_fire;
    logic              w_load;
    logic              w_chain_in;
    logic [DOUT_N-1:0] w_unused_dout_par;

    // Self-strobe on the last cycle of a frame; OR with stb so a coincident stb is one load.
    assign w_auto_fire = (AUTO_STB == STB_AUTO) && (r_bcnt == CNT_W'(FRAME - 1));
    assign w_load      = bus.i_stb | w_auto_fire;

    // Cycles since the last load, saturating at FRAME.
    always_comb begin
        w_bcnt_nxt = r_bcnt;
        if (w_load) begin
            w_bcnt_nxt = '0;
        end else if (r_bcnt != CNT_W'(FRAME)) begin
            w_bcnt_nxt = r_bcnt + CNT_W'(1);
        end
    end

    if (DIN_N == 0) begin : g_no_din
        // No input chain: di feeds the output chain directly.
        assign w_chain_in   = bus.i_di;
        assign bus.o_din    = '0;
        assign w_full_nxt   = 1'b1;
    end else begin : g_din
        logic [DIN_N-1:0] w_din_shr;
        logic [DIN_N-1:0] r_din;

        // Input chain never loads; it shifts every cycle, including load cycles.
        shr_chain #(.W(DIN_N)) u_din_chain (
            .clk    (clk),
            .rst    (rst),
            .i_load (1'b0),
            .i_ser  (bus.i_di),
            .i_par  ({DIN_N{1'b0}}),
            .o_msb  (w_chain_in),
            .o_par  (w_din_shr)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_din <= '0;
            end else if (w_load) begin
                r_din <= w_din_shr;
            end
        end

        assign bus.o_din  = r_din;
        assign w_full_nxt = (w_bcnt_nxt >= CNT_W'(DIN_N));
    end

    // Output chain captures the ROI result on a load, otherwise shifts toward do.
    shr_chain #(.W(DOUT_N)) u_dout_chain (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_ser  (w_chain_in),
        .i_par  (bus.i_dout),
        .o_msb  (bus.o_do),
        .o_par  (w_unused_dout_par)
    );

    // Frame counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt       <= '0;
            r_ld         <= 1'b0;
            r_frame_full <= 1'(DIN_N == 0);
        end else begin
            r_bcnt       <= w_bcnt_nxt;
            r_ld         <= w_load;
            r_frame_full <= w_full_nxt;
        end
    end

    assign bus.o_ld         = r_ld;
    assign bus.o_frame_full = r_frame_full;

endmodule

// File: tb/tb_roi_shr_harness.sv
module tb_roi_shr_harness;

    localparam int NCFG = 5;
    localparam int NCYC = 3000;

    // Configurations under test: {DIN_N, DOUT_N, AUTO_STB}.
    localparam int DIN_C  [NCFG] = '{4, 0, 3, 8, 32};
    localparam int DOUT_C [NCFG] = '{4, 1, 5, 4, 32};
    localparam bit AUTO_C [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        int          cfg;
        int          e;
        bit          exp_do;
        bit          exp_ld;
        bit          exp_ff;
        logic [31:0] exp_din;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        di;
    logic [31:0] dout_v [NCFG];

    int checks;
    int failures;

    exp_t exp_q [$];

    // Input history, indexed by the clock edge that sampled it.
    bit          di_h   [NCYC];
    bit          rst_h  [NCYC];
    bit          stb_h  [NCYC];
    logic [31:0] dout_h [NCFG][NCYC];

    // Reference-model bookkeeping per configuration.
    int last_ev   [NCFG];
    bit ev_is_rst [NCFG];
    int last_rst  [NCFG];
    int last_load [NCFG];

    roi_shr_harness_if #(.DIN_N(4),  .DOUT_N(4))  if0 ();
    roi_shr_harness_if #(.DIN_N(0),  .DOUT_N(1))  if1 ();
    roi_shr_harness_if #(.DIN_N(3),  .DOUT_N(5))  if2 ();
    roi_shr_harness_if #(.DIN_N(8),  .DOUT_N(4))  if3 ();
    roi_shr_harness_if #(.DIN_N(32), .DOUT_N(32)) if4 ();

    roi_shr_harness #(.DIN_N(4),  .DOUT_N(4),  .AUTO_STB(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    roi_shr_harness #(.DIN_N(0),  .DOUT_N(1),  .AUTO_STB(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    roi_shr_harness #(.DIN_N(3),  .DOUT_N(5),  .AUTO_STB(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    roi_shr_harness #(.DIN_N(8),  .DOUT_N(4),  .AUTO_STB(1'b1)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    roi_shr_harness #(.DIN_N(32), .DOUT_N(32), .AUTO_STB(1'b0)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    assign if0.i_stb = stb;  assign if0.i_di = di;  assign if0.i_dout = dout_v[0][3:0];
    assign if1.i_stb = stb;  assign if1.i_di = di;  assign if1.i_dout = dout_v[1][0:0];
    assign if2.i_stb = stb;  assign if2.i_di = di;  assign if2.i_dout = dout_v[2][4:0];
    assign if3.i_stb = stb;  assign if3.i_di = di;  assign if3.i_dout = dout_v[3][3:0];
    assign if4.i_stb = stb;  assign if4.i_di = di;  assign if4.i_dout = dout_v[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit entering the output chain at edge j: di delayed by DIN_N edges,
    // with anything sampled at or before the last reset reading as 0.
    function automatic bit chain_in(input int c, input int j);
        int src;
        if (DIN_C[c] == 0) return di_h[j];
        src = j - DIN_C[c];
        return (src > last_rst[c]) ? di_h[src] : 1'b0;
    endfunction

    // Expected outputs after edge e for configuration c.
    function automatic exp_t predict(input int c, input int e, input bit ld);
        exp_t x;
        int   k;
        int   fr;
        int   since;
        fr        = (DIN_C[c] > DOUT_C[c]) ? DIN_C[c] : DOUT_C[c];
        x.cfg     = c;
        x.e       = e;
        x.exp_ld  = ld;
        k         = e - last_ev[c];
        if (k < DOUT_C[c]) begin
            // Still unloading the word captured (or zeroed) at the last event.
            if (ev_is_rst[c]) x.exp_do = 1'b0;
            else              x.exp_do = dout_h[c][last_ev[c]][DOUT_C[c] - 1 - k];
        end else begin
            x.exp_do = chain_in(c, e - DOUT_C[c] + 1);
        end
        x.exp_din = '0;
        if (last_load[c] >= 0) begin
            for (int i = 0; i < DIN_C[c]; i++) begin
                if (last_load[c] - 1 - i > last_rst[c])
                    x.exp_din[i] = di_h[last_load[c] - 1 - i];
            end
        end
        since    = (k > fr) ? fr : k;
        x.exp_ff = (DIN_C[c] == 0) ? 1'b1 : (since >= DIN_C[c]);
        return x;
    endfunction

    // Advance the model by one edge and queue the expected response.
    task automatic model_step(input int e);
        bit   ld;
        bit   auto_f;
        int   fr;
        exp_t x;
        for (int c = 0; c < NCFG; c++) begin
            fr = (DIN_C[c] > DOUT_C[c]) ? DIN_C[c] : DOUT_C[c];
            ld = 1'b0;
            if (rst_h[e]) begin
                last_ev[c]   = e;
                ev_is_rst[c] = 1'b1;
                last_rst[c]  = e;
                last_load[c] = -1;
            end else begin
                auto_f = AUTO_C[c] && ((e - last_ev[c]) == fr);
                ld     = stb_h[e] || auto_f;
                if (ld) begin
                    last_ev[c]   = e;
                    ev_is_rst[c] = 1'b0;
                    last_load[c] = e;
                end
            end
            x = predict(c, e, ld);
            exp_q.push_back(x);
        end
    endtask

    // Stimulus: reset, a quiet stretch of pure shifting, then random loads and resets.
    initial begin : stimulus
        int n;
        int p_stb;
        rst = 1'b1;
        stb = 1'b0;
        di  = 1'b0;
        for (int c = 0; c < NCFG; c++) begin
            dout_v[c]    = $urandom();
            last_ev[c]   = 0;
            ev_is_rst[c] = 1'b1;
            last_rst[c]  = 0;
            last_load[c] = -1;
        end
        for (int e = 0; e < NCYC; e++) begin
            @(posedge clk);
            di_h[e]  = di;
            rst_h[e] = rst;
            stb_h[e] = stb;
            for (int c = 0; c < NCFG; c++) dout_h[c][e] = dout_v[c];
            model_step(e);
            #1;
            n   = e + 1;
            di  = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCFG; c++) dout_v[c] = $urandom();
            rst = 1'b0;
            stb = 1'b0;
            if (n < 3) begin
                rst = 1'b1;
            end else if (n >= 60) begin
                p_stb = (n < 1500) ? 30 : 5;
                stb   = ($urandom_range(0, p_stb - 1) == 0);
                if ($urandom_range(0, 199) == 0) begin
                    rst = 1'b1;
                    stb = ($urandom_range(0, 2) == 0);
                end
                if (n == 1000 || n == 2200) begin
                    rst = 1'b1;
                    stb = 1'b1;
                end
            end
        end
    end

    task automatic cmp(input string name, input int c, input int e,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cfg%0d edge%0d got=%0h want=%0h", name, c, e, got, want);
        end
    endtask

    // Monitor: every cycle, compare each DUT against the queued expectation.
    initial begin : monitor
        exp_t        x;
        logic        a_do;
        logic        a_ld;
        logic        a_ff;
        logic [31:0] a_din;
        checks   = 0;
        failures = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                case (x.cfg)
                    0: begin a_do = if0.o_do; a_ld = if0.o_ld; a_ff = if0.o_frame_full; a_din = 32'(if0.o_din); end
                    1: begin a_do = if1.o_do; a_ld = if1.o_ld; a_ff = if1.o_frame_full; a_din = 32'(if1.o_din); end
                    2: begin a_do = if2.o_do; a_ld = if2.o_ld; a_ff = if2.o_frame_full; a_din = 32'(if2.o_din); end
                    3: begin a_do = if3.o_do; a_ld = if3.o_ld; a_ff = if3.o_frame_full; a_din = 32'(if3.o_din); end
                    default: begin a_do = if4.o_do; a_ld = if4.o_ld; a_ff = if4.o_frame_full; a_din = if4.o_din; end
                endcase
                cmp("do",         x.cfg, x.e, 32'(a_do), 32'(x.exp_do));
                cmp("ld",         x.cfg, x.e, 32'(a_ld), 32'(x.exp_ld));
                cmp("frame_full", x.cfg, x.e, 32'(a_ff), 32'(x.exp_ff));
                cmp("din",        x.cfg, x.e, a_din,     x.exp_din);
            end
        end
        cmp("queue_drained", 0, NCYC, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
